// File: rtl/ps_conv3x3_top.sv
// ps_conv3x3_top: 3x3 spatial filter stage (bypass/gaussian/sharpen/laplacian).
// Pulls pixels from an upstream FIFO, builds 3x3 windows from two line buffers,
// filters them and queues results in an internal FWFT output FIFO. Reads are
// credit-throttled against obuf occupancy plus pixels still in the pipeline.
module ps_conv3x3_top #(
    parameter int DATA_WIDTH        = 8,
    parameter int LINE_WIDTH        = 640,
    parameter int OBUF_AW           = 4,
    parameter int ALMOSTFULL_OFFSET = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic [1:0]            i_mode,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_almostempty,
    output logic                  o_rd,
    input  logic                  i_obuf_rd,
    output logic [DATA_WIDTH-1:0] o_obuf_data,
    output logic [OBUF_AW:0]      o_obuf_fill,
    output logic                  o_obuf_full,
    output logic                  o_obuf_empty,
    output logic                  o_busy,
    output logic                  o_err
);
    localparam int DW    = DATA_WIDTH;
    localparam int DEPTH = 2 ** OBUF_AW;
    localparam int CW    = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [0:0]        state, nxt_state;
    logic              nxt_rd, can_rd, din_valid;
    logic [1:0]        cfg_mode;
    logic              bypass, win_ok;
    logic [CW-1:0]     col;
    logic [1:0]        row;
    logic [2:0]        inflight;
    logic [OBUF_AW+1:0] credit_used;

    logic [DW-1:0]     lb0 [LINE_WIDTH];
    logic [DW-1:0]     lb1 [LINE_WIDTH];
    logic [DW-1:0]     top_n, mid_n;
    logic [DW-1:0]     w_t1, w_t2, w_m1, w_m2, w_b1, w_b2;
    logic [DW+1:0]     corner_sum, edge_sum;

    logic              s1_valid, s2_valid;
    logic [DW+1:0]     s1_corner, s1_edge;
    logic [DW-1:0]     s1_centre, s2_data;
    logic [DW+3:0]     cc_x, edge_x, g_sum, sh_sum, lp_sum, lp_abs;
    logic [DW-1:0]     filt;
    logic [3:0]        unused_gauss_lsbs;

    logic              wr_req, do_wr, do_rd;
    logic [DW-1:0]     wr_data;
    logic [DW-1:0]     obuf_mem [DEPTH];
    logic [OBUF_AW-1:0] wptr, rptr;

    assign bypass   = (cfg_mode == 2'd0);
    assign win_ok   = (row == 2'd2) && (col >= CW'(2));
    assign inflight = {2'b0, o_rd} + {2'b0, din_valid} + {2'b0, s1_valid} + {2'b0, s2_valid};
    assign credit_used = {1'b0, o_obuf_fill} + {{(OBUF_AW-1){1'b0}}, inflight};
    assign can_rd   = !i_almostempty && !i_flush &&
                      (credit_used < (OBUF_AW+2)'(DEPTH - ALMOSTFULL_OFFSET));
    assign o_busy   = o_rd | din_valid | s1_valid | s2_valid;

    // Read-control FSM next state: keep reading while credit allows
    always_comb begin
        nxt_state = state;
        nxt_rd    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (can_rd) begin
                    nxt_state = ST_ACTIVE;
                    nxt_rd    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                nxt_rd = can_rd;
                if (!can_rd) nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Control registers: FSM, read strobe, data-valid, mode and position counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            o_rd      <= 1'b0;
            din_valid <= 1'b0;
            cfg_mode  <= 2'd0;
            col       <= '0;
            row       <= 2'd0;
        end else if (i_flush) begin
            state     <= ST_IDLE;
            o_rd      <= 1'b0;
            din_valid <= 1'b0;
            cfg_mode  <= i_mode;
            col       <= '0;
            row       <= 2'd0;
        end else begin
            state     <= nxt_state;
            o_rd      <= nxt_rd;
            din_valid <= o_rd;
            if (din_valid) begin
                if (col == CW'(LINE_WIDTH - 1)) begin
                    col <= '0;
                    if (row != 2'd2) row <= row + 2'd1;
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Line buffers: lb0 holds the previous line, lb1 the one before it
    always_ff @(posedge i_clk) begin
        if (din_valid && !i_flush) begin
            lb1[col] <= lb0[col];
            lb0[col] <= i_data;
        end
    end

    assign top_n = lb1[col];
    assign mid_n = lb0[col];
    // Window is {w_*1, w_*2, incoming column}; corners/edges are summed before registering
    assign corner_sum = {2'b0, w_t1} + {2'b0, top_n} + {2'b0, w_b1} + {2'b0, i_data};
    assign edge_sum   = {2'b0, w_t2} + {2'b0, w_b2} + {2'b0, w_m1} + {2'b0, mid_n};

    // Window shift and stage 1 (partial sums, or raw pixel in bypass)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            {w_t1, w_t2, w_m1, w_m2, w_b1, w_b2} <= '0;
            s1_valid  <= 1'b0;
            s1_corner <= '0;
            s1_edge   <= '0;
            s1_centre <= '0;
        end else if (i_flush) begin
            s1_valid  <= 1'b0;
        end else begin
            s1_valid <= din_valid && (bypass || win_ok);
            if (din_valid) begin
                w_t1 <= w_t2;  w_t2 <= top_n;
                w_m1 <= w_m2;  w_m2 <= mid_n;
                w_b1 <= w_b2;  w_b2 <= i_data;
                s1_corner <= corner_sum;
                s1_edge   <= edge_sum;
                s1_centre <= bypass ? i_data : w_m2;
            end
        end
    end

    assign cc_x   = {4'b0, s1_centre};
    assign edge_x = {2'b0, s1_edge};
    assign g_sum  = {2'b0, s1_corner} + (edge_x << 1) + (cc_x << 2);
    assign sh_sum = (cc_x << 2) + cc_x - edge_x;
    assign lp_sum = edge_x - (cc_x << 2);
    assign lp_abs = lp_sum[DW+3] ? (~lp_sum + (DW+4)'(1)) : lp_sum;
    assign unused_gauss_lsbs = g_sum[3:0];

    // Stage 2 combinational kernel: scale, clamp or saturate per mode
    always_comb begin
        filt = s1_centre;
        case (cfg_mode)
            2'd1: filt = g_sum[DW+3:4];
            2'd2: begin
                if (sh_sum[DW+3])             filt = '0;
                else if (|sh_sum[DW+2:DW])    filt = '1;
                else                          filt = sh_sum[DW-1:0];
            end
            2'd3: filt = (|lp_abs[DW+3:DW]) ? '1 : lp_abs[DW-1:0];
            default: filt = s1_centre;
        endcase
    end

    // Stage 2 register: filtered result awaiting obuf write
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (i_flush) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid && !bypass;
            s2_data  <= filt;
        end
    end

    assign wr_req  = bypass ? s1_valid : s2_valid;
    assign wr_data = bypass ? s1_centre : s2_data;
    assign do_wr   = wr_req && !o_obuf_full;
    assign do_rd   = i_obuf_rd && !o_obuf_empty;

    assign o_obuf_full  = (o_obuf_fill == (OBUF_AW+1)'(DEPTH));
    assign o_obuf_empty = (o_obuf_fill == '0);
    assign o_obuf_data  = o_obuf_empty ? '0 : obuf_mem[rptr];

    // Output FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr        <= '0;
            rptr        <= '0;
            o_obuf_fill <= '0;
            o_err       <= 1'b0;
        end else if (i_flush) begin
            wptr        <= '0;
            rptr        <= '0;
            o_obuf_fill <= '0;
            o_err       <= 1'b0;
        end else begin
            if (wr_req && o_obuf_full) o_err <= 1'b1;
            if (do_wr) wptr <= wptr + OBUF_AW'(1);
            if (do_rd) rptr <= rptr + OBUF_AW'(1);
            case ({do_wr, do_rd})
                2'b10:   o_obuf_fill <= o_obuf_fill + (OBUF_AW+1)'(1);
                2'b01:   o_obuf_fill <= o_obuf_fill - (OBUF_AW+1)'(1);
                default: o_obuf_fill <= o_obuf_fill;
            endcase
        end
    end

    // Output FIFO storage
    always_ff @(posedge i_clk) begin
        if (do_wr) obuf_mem[wptr] <= wr_data;
    end
endmodule

// File: tb/tb_ps_conv3x3_top.sv
// Testbench for ps_conv3x3_top: directed frames with hand-computed results,
// scoreboard queue filled by stimulus, popped by an output monitor.
module tb_ps_conv3x3_top;
    localparam int DW = 8;
    localparam int LW = 8;
    localparam int AW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_flush = 1'b0;
    logic [1:0]    i_mode = 2'd0;
    logic [DW-1:0] i_data = '0;
    logic          i_almostempty;
    logic          o_rd;
    logic          i_obuf_rd = 1'b0;
    logic [DW-1:0] o_obuf_data;
    logic [AW:0]   o_obuf_fill;
    logic          o_obuf_full, o_obuf_empty, o_busy, o_err;

    ps_conv3x3_top #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .OBUF_AW(AW), .ALMOSTFULL_OFFSET(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_mode(i_mode),
        .i_data(i_data), .i_almostempty(i_almostempty), .o_rd(o_rd),
        .i_obuf_rd(i_obuf_rd), .o_obuf_data(o_obuf_data), .o_obuf_fill(o_obuf_fill),
        .o_obuf_full(o_obuf_full), .o_obuf_empty(o_obuf_empty), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int passes = 0;
    int total  = 0;
    int max_fill = 0;
    bit drain = 1'b0;
    logic [7:0] exp_q [$];

    logic [7:0] src [0:1023];
    int src_cnt = 0;
    int rd_idx  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Upstream FIFO model: data one cycle after the read strobe
    assign i_almostempty = (src_cnt - rd_idx - int'(o_rd)) < 1;
    always @(posedge i_clk) begin
        if (o_rd && rd_idx < src_cnt) begin
            i_data <= src[rd_idx];
            rd_idx <= rd_idx + 1;
        end
    end

    // Output monitor: pops the scoreboard whenever it reads an obuf entry
    always @(negedge i_clk) begin
        if (int'(o_obuf_fill) > max_fill) max_fill = int'(o_obuf_fill);
        if (drain && !o_obuf_empty && !i_rst && !i_flush) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", int'(o_obuf_data), -1);
            end else begin
                chk("obuf_data", int'(o_obuf_data), int'(exp_q.pop_front()));
            end
            i_obuf_rd = 1'b1;
        end else begin
            i_obuf_rd = 1'b0;
        end
    end

    task automatic push_px(input logic [7:0] v);
        src[src_cnt] = v;
        src_cnt++;
    endtask

    task automatic push_line(input logic [7:0] l [LW]);
        for (int unsigned i = 0; i < LW; i++) push_px(l[i]);
    endtask

    task automatic frame(input logic [1:0] mode);
        @(negedge i_clk);
        i_flush = 1'b1;
        i_mode  = mode;
        @(negedge i_clk);
        i_flush = 1'b0;
        i_mode  = 2'd0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && rd_idx == src_cnt && !o_busy && o_obuf_empty) && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        chk(name, int'(n < budget), 1);
        repeat (4) @(negedge i_clk);
    endtask

    logic [7:0] l0 [LW];
    logic [7:0] l1 [LW];
    logic [7:0] l2 [LW];

    initial begin
        int k;
        // Reset state
        repeat (2) @(negedge i_clk);
        chk("rst_o_rd", int'(o_rd), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_err", int'(o_err), 0);
        chk("rst_fill", int'(o_obuf_fill), 0);
        chk("rst_empty", int'(o_obuf_empty), 1);
        chk("rst_full", int'(o_obuf_full), 0);
        chk("rst_data", int'(o_obuf_data), 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // 1 Bypass 0x10..0x1F, check first write latency
        drain = 1'b1;
        frame(2'd0);
        for (int unsigned i = 0; i < 16; i++) begin
            push_px(8'(8'h10 + i));
            exp_q.push_back(8'(8'h10 + i));
        end
        k = 0;
        while (!o_rd && k < 10) begin @(negedge i_clk); k++; end
        chk("byp_rd_seen", int'(k < 10), 1);
        k = 0;
        while (o_obuf_empty && k < 10) begin @(negedge i_clk); k++; end
        chk("byp_first_write_latency", k, 3);
        wait_done("byp_done", 300);

        // 2 Gaussian flat field: 6 outputs of 100
        frame(2'd1);
        for (int unsigned i = 0; i < 24; i++) push_px(8'd100);
        for (int unsigned i = 0; i < 6; i++) exp_q.push_back(8'd100);
        wait_done("gauss_done", 300);

        // 3a Sharpen: lone bright centre -> 255 (clamped), neighbours 0
        frame(2'd2);
        l0 = '{default: 8'd0};
        l1 = '{8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        l2 = '{default: 8'd0};
        push_line(l0); push_line(l1); push_line(l2);
        exp_q.push_back(8'd255);
        for (int unsigned i = 0; i < 5; i++) exp_q.push_back(8'd0);
        wait_done("sharp_a_done", 300);

        // 3b Sharpen: dark centre with bright neighbours -> 0 (clamped)
        frame(2'd2);
        l0 = '{default: 8'd255};
        l1 = '{8'd255, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255};
        l2 = '{default: 8'd255};
        push_line(l0); push_line(l1); push_line(l2);
        exp_q.push_back(8'd255); exp_q.push_back(8'd255); exp_q.push_back(8'd0);
        exp_q.push_back(8'd255); exp_q.push_back(8'd255); exp_q.push_back(8'd255);
        wait_done("sharp_b_done", 300);

        // 4 Laplacian |edges - 4*centre|
        frame(2'd3);
        l0 = '{8'd0, 8'd0, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        l1 = '{8'd0, 8'd20, 8'd10, 8'd20, 8'd0, 8'd40, 8'd0, 8'd0};
        l2 = '{8'd0, 8'd0, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        push_line(l0); push_line(l1); push_line(l2);
        exp_q.push_back(8'd70);  exp_q.push_back(8'd40); exp_q.push_back(8'd70);
        exp_q.push_back(8'd60);  exp_q.push_back(8'd160); exp_q.push_back(8'd40);
        wait_done("lap_done", 300);

        // 5 Backpressure: no drain, credit must stop reads at fill 14
        drain = 1'b0;
        frame(2'd0);
        for (int unsigned i = 0; i < 100; i++) begin
            push_px(8'((i * 7 + 3) & 255));
            exp_q.push_back(8'((i * 7 + 3) & 255));
        end
        repeat (80) @(negedge i_clk);
        chk("bp_o_rd", int'(o_rd), 0);
        chk("bp_fill", int'(o_obuf_fill), 14);
        chk("bp_max_fill", max_fill, 14);
        chk("bp_full", int'(o_obuf_full), 0);
        chk("bp_err", int'(o_err), 0);
        drain = 1'b1;
        wait_done("bp_drain_done", 2000);
        chk("bp_max_fill_after", max_fill, 14);

        // 6 Flush at row1,col5 loading sharpen mode
        drain = 1'b0;
        frame(2'd0);
        for (int unsigned i = 0; i < 13; i++) push_px(8'(i + 1));
        k = 0;
        while ((o_busy || rd_idx != src_cnt) && k < 100) begin @(negedge i_clk); k++; end
        chk("fl_pre_idle", int'(k < 100), 1);
        chk("fl_pre_fill", int'(o_obuf_fill), 13);
        chk("fl_pre_row", int'(dut.row), 1);
        chk("fl_pre_col", int'(dut.col), 5);
        i_flush = 1'b1;
        i_mode  = 2'd2;
        @(negedge i_clk);
        i_flush = 1'b0;
        i_mode  = 2'd0;
        chk("fl_fill", int'(o_obuf_fill), 0);
        chk("fl_empty", int'(o_obuf_empty), 1);
        chk("fl_o_rd", int'(o_rd), 0);
        chk("fl_cfg_mode", int'(dut.cfg_mode), 2);
        drain = 1'b1;
        for (int unsigned i = 0; i < 24; i++) push_px(8'd7);
        for (int unsigned i = 0; i < 6; i++) exp_q.push_back(8'd7);
        wait_done("fl_frame_done", 300);

        chk("final_err", int'(o_err), 0);
        chk("final_empty", int'(o_obuf_empty), 1);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passes, total);
        $fatal(1);
    end
endmodule
